// File: rtl/uart_rx.sv
// uart_rx: oversampled 8N1 serial receiver with status/data registers on the 6809 bus.
// Define UART_RX_PARITY_EN to add an even-parity bit per frame and the PE status flag.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 6
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  input  logic       R,
  input  logic       ADDR,
  inout  wire  [7:0] DATA,
  output logic       RXRDY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t             state;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         idx;
  logic [7:0]         shreg;
  logic [7:0]         hold;
  logic               rx_m;
  logic               rx_s;
  logic               r_q;
  logic               armed;
  logic               ovr;
  logic               fe;
  logic               pe;
  logic               pe_new;
  logic               half_t;
  logic               full_t;
  logic               done;
  logic               rd_clr;
  logic [7:0]         status;

  assign half_t = (cnt == CNT_W'(OVERSAMPLE / 2 - 1));
  assign full_t = (cnt == CNT_W'(OVERSAMPLE - 1));
  assign rd_clr = R && !r_q && ADDR;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      r_q  <= 1'b1;
    end else begin
      rx_m <= RXD;
      rx_s <= rx_m;
      r_q  <= R;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    done    = 1'b0;
    unique case (state)
      S_IDLE:  if (armed && !rx_s) state_d = S_START;
      S_START: if (half_t) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:
        if (full_t && idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (full_t) state_d = S_STOP;
`endif
      S_STOP:
        if (full_t) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      if (state == S_IDLE || state_d != state || full_t)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
      if (state == S_START)
        idx <= '0;
      else if (state == S_DATA && full_t)
        idx <= idx + 3'd1;
      if (state == S_DATA && full_t)
        shreg[idx] <= rx_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge CLK) begin
    if (RST)
      par_bit <= 1'b0;
    else if (state == S_PARITY && full_t)
      par_bit <= rx_s;
  end

  assign pe_new = ^{shreg, par_bit};
`else
  assign pe_new = 1'b0;
`endif

  // A completing frame takes priority over a coincident read-clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold  <= '0;
      RXRDY <= 1'b0;
      ovr   <= 1'b0;
      fe    <= 1'b0;
      pe    <= 1'b0;
    end else if (done) begin
      if (!RXRDY || rd_clr) begin
        hold  <= shreg;
        RXRDY <= 1'b1;
        ovr   <= 1'b0;
        fe    <= !rx_s;
        pe    <= pe_new;
      end else begin
        ovr   <= 1'b1;
      end
    end else if (rd_clr) begin
      RXRDY <= 1'b0;
      ovr   <= 1'b0;
      fe    <= 1'b0;
      pe    <= 1'b0;
    end
  end

  // Re-arm only after the line returns high so a break yields one frame.
  always_ff @(posedge CLK) begin
    if (RST)       armed <= 1'b0;
    else if (done) armed <= 1'b0;
    else if (rx_s) armed <= 1'b1;
  end

  assign status = {4'b0, pe, fe, ovr, RXRDY};
  assign DATA   = !R ? (ADDR ? hold : status) : 8'hzz;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx with hand-computed status/data values.
// Parity cases build only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RXD;
  logic       R;
  logic       ADDR;
  wire  [7:0] DATA;
  logic       RXRDY;

  int nchk = 0;
  int nerr = 0;
  int cyc;
  int rdy_at;
  logic [7:0] v;

`ifdef UART_RX_PARITY_EN
  localparam int RDY_CYC = 171;
`else
  localparam int RDY_CYC = 155;
`endif

  uart_rx #(.OVERSAMPLE(16), .CNT_W(6)) dut (
    .CLK(CLK),
    .RST(RST),
    .RXD(RXD),
    .R(R),
    .ADDR(ADDR),
    .DATA(DATA),
    .RXRDY(RXRDY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int got, input int exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    cyc++;
    if (RXRDY && rdy_at < 0) rdy_at = cyc;
  endtask

  task automatic bit_out(input logic b);
    RXD = b;
    repeat (16) tick();
  endtask

  task automatic send(input logic [7:0] b, input logic stp, input logic par);
    cyc    = 0;
    rdy_at = -1;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(par);
`else
    if (par) cyc = cyc + 0;
`endif
    bit_out(stp);
    bit_out(1'b1);
    bit_out(1'b1);
  endtask

  task automatic rd(input logic a, output logic [7:0] d);
    ADDR = a;
    R    = 1'b0;
    #1 d = DATA;
    @(negedge CLK);
    R = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    ADDR = 1'b0;
  endtask

  initial begin
    RST  = 1'b1;
    RXD  = 1'b1;
    R    = 1'b1;
    ADDR = 1'b0;
    repeat (4) @(negedge CLK);
    chk("reset_rxrdy", {7'b0, RXRDY}, 8'h00);
    RST = 1'b0;
    repeat (500) @(negedge CLK);
    chk("idle_rxrdy", {7'b0, RXRDY}, 8'h00);
    rd(1'b0, v); chk("idle_status", v, 8'h00);
    rd(1'b1, v); chk("idle_data", v, 8'h00);

    send(8'h55, 1'b1, 1'b0);
    chk_i("rdy_latency", rdy_at, RDY_CYC);
    rd(1'b0, v); chk("s55_status", v, 8'h01);
    rd(1'b1, v); chk("s55_data", v, 8'h55);
    rd(1'b0, v); chk("s55_status_clr", v, 8'h00);
    chk("s55_rxrdy_clr", {7'b0, RXRDY}, 8'h00);

    send(8'hA3, 1'b1, 1'b0);
    send(8'h3C, 1'b1, 1'b0);
    rd(1'b0, v); chk("ovr_status", v, 8'h03);
    rd(1'b1, v); chk("ovr_data", v, 8'hA3);
    rd(1'b0, v); chk("ovr_status_clr", v, 8'h00);

    send(8'h7E, 1'b0, 1'b0);
    rd(1'b0, v); chk("fe_status", v, 8'h05);
    rd(1'b1, v); chk("fe_data", v, 8'h7E);
    rd(1'b0, v); chk("fe_status_clr", v, 8'h00);

    RXD = 1'b0;
    repeat (5) @(negedge CLK);
    RXD = 1'b1;
    repeat (60) @(negedge CLK);
    chk("glitch_rxrdy", {7'b0, RXRDY}, 8'h00);
    rd(1'b0, v); chk("glitch_status", v, 8'h00);

    cyc = 0;
    rdy_at = -1;
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b1);
    RST = 1'b1;
    RXD = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (32) @(negedge CLK);
    chk("rst_mid_rxrdy", {7'b0, RXRDY}, 8'h00);
    send(8'h81, 1'b1, 1'b0);
    rd(1'b0, v); chk("s81_status", v, 8'h01);
    rd(1'b1, v); chk("s81_data", v, 8'h81);

    RXD = 1'b0;
    repeat (400) @(negedge CLK);
    rd(1'b0, v); chk("break_status", v, 8'h05);
    RXD = 1'b1;
    repeat (40) @(negedge CLK);
    rd(1'b1, v); chk("break_data", v, 8'h00);
    rd(1'b0, v); chk("break_status_clr", v, 8'h00);

`ifdef UART_RX_PARITY_EN
    send(8'h01, 1'b1, 1'b0);
    rd(1'b0, v); chk("pe_status", v, 8'h09);
    rd(1'b1, v); chk("pe_data", v, 8'h01);
    send(8'h03, 1'b1, 1'b0);
    rd(1'b0, v); chk("pok_status", v, 8'h01);
    rd(1'b1, v); chk("pok_data", v, 8'h03);
    rd(1'b0, v); chk("pok_status_clr", v, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
